// File: rtl/seven_segment_arbiter.sv
// Round-robin arbiter sharing one seven-segment display between NUM_REQ requesters.
// Each grant is held for HOLD_CYCLES unless its owner drops its request first.
module seven_segment_arbiter #(
    parameter int          NUM_REQ     = 4,
    parameter int          HOLD_CYCLES = 50_000_000,
    parameter logic [31:0] IDLE_VAL    = 32'h0000_0000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [NUM_REQ*32-1:0]      val_in,
    output logic [NUM_REQ-1:0]         grant_out,
    output logic [$clog2(NUM_REQ)-1:0] owner_out,
    output logic                       busy_out,
    output logic [31:0]                val_out
);

    localparam int          OW        = $clog2(NUM_REQ);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [OW-1:0] LAST_IDX = OW'(NUM_REQ - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [31:0]         val_q, val_d;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   scan;
    logic [OW-1:0]        pick;
    logic                 found;
    logic                 owner_req;
    logic [31:0]          owner_val;
    logic                 release_ev;

    // Rotate requests so bit 0 is owner+1 and the owner itself lands in the top bit.
    always_comb begin
        req_dbl = {req_in, req_in};
        req_rot = NUM_REQ'(req_dbl >> (int'(owner_q) + 1));
        scan    = req_rot;
        pick    = owner_q;
        found   = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && scan[0]) begin
                pick  = OW'((int'(owner_q) + 1 + j) % NUM_REQ);
                found = 1'b1;
            end
            scan = scan >> 1;
        end
    end

    always_comb begin
        owner_req  = |(req_in & (NUM_REQ'(1) << owner_q));
        owner_val  = 32'(val_in >> (32 * int'(owner_q)));
        release_ev = (cnt_q == HOLD_LAST) || !owner_req;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        case (state_q)
            IDLE: begin
                if (|req_in) begin
                    state_d = HOLD;
                    owner_d = pick;
                    grant_d = NUM_REQ'(1) << pick;
                    cnt_d   = 32'd0;
                end
            end
            HOLD: begin
                val_d = owner_val;
                if (release_ev) begin
                    cnt_d = 32'd0;
                    if (req_in == '0) begin
                        // Owner is kept so the next scan starts after it.
                        state_d = IDLE;
                        grant_d = '0;
                    end else begin
                        owner_d = pick;
                        grant_d = NUM_REQ'(1) << pick;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            owner_q <= LAST_IDX;
            grant_q <= '0;
            cnt_q   <= 32'd0;
            val_q   <= IDLE_VAL;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
        end
    end

    assign grant_out = grant_q;
    assign owner_out = owner_q;
    assign busy_out  = (state_q == HOLD);
    assign val_out   = val_q;

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Directed bench for seven_segment_arbiter: a cycle table with HOLD_CYCLES=4,
// async mid-hold reset, and a second instance with HOLD_CYCLES=1.
module tb_seven_segment_arbiter;

    localparam logic [31:0] V0 = 32'h1111_0000;
    localparam logic [31:0] V1 = 32'h2222_1111;
    localparam logic [31:0] V2 = 32'hDEAD_BEEF;
    localparam logic [31:0] V3 = 32'h4444_3333;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   req1;
    logic [127:0] val;
    logic [3:0]   grant, grant1;
    logic [1:0]   owner, owner1;
    logic         busy, busy1;
    logic [31:0]  vout, vout1;

    int total = 0;
    int bad   = 0;

    seven_segment_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4), .IDLE_VAL(32'h0)) dut (
        .clk_in(clk), .rst_in(rst_n), .req_in(req), .val_in(val),
        .grant_out(grant), .owner_out(owner), .busy_out(busy), .val_out(vout)
    );

    seven_segment_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(1), .IDLE_VAL(32'h0)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .req_in(req1), .val_in(val),
        .grant_out(grant1), .owner_out(owner1), .busy_out(busy1), .val_out(vout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic [31:0] val;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                             input logic [31:0] v);
        check({tag, " grant"}, 32'(grant), 32'(g));
        check({tag, " owner"}, 32'(owner), 32'(o));
        check({tag, " busy"},  32'(busy),  32'(g != 4'b0000));
        check({tag, " val"},   vout,       v);
    endtask

    initial begin
        // Single requester 2, expiry re-grant, early release to 3, rotation, drop-all, no preemption.
        vecs[0]  = '{4'b0100, 4'b0100, 2'd2, 32'h0};
        vecs[1]  = '{4'b0100, 4'b0100, 2'd2, V2};
        vecs[2]  = '{4'b0100, 4'b0100, 2'd2, V2};
        vecs[3]  = '{4'b0100, 4'b0100, 2'd2, V2};
        vecs[4]  = '{4'b0100, 4'b0100, 2'd2, V2};
        vecs[5]  = '{4'b0100, 4'b0100, 2'd2, V2};
        vecs[6]  = '{4'b1011, 4'b1000, 2'd3, V2};
        vecs[7]  = '{4'b1011, 4'b1000, 2'd3, V3};
        vecs[8]  = '{4'b1011, 4'b1000, 2'd3, V3};
        vecs[9]  = '{4'b1011, 4'b1000, 2'd3, V3};
        vecs[10] = '{4'b1011, 4'b0001, 2'd0, V3};
        vecs[11] = '{4'b1011, 4'b0001, 2'd0, V0};
        vecs[12] = '{4'b1011, 4'b0001, 2'd0, V0};
        vecs[13] = '{4'b1011, 4'b0001, 2'd0, V0};
        vecs[14] = '{4'b1011, 4'b0010, 2'd1, V0};
        vecs[15] = '{4'b1011, 4'b0010, 2'd1, V1};
        vecs[16] = '{4'b0100, 4'b0100, 2'd2, V1};
        vecs[17] = '{4'b0100, 4'b0100, 2'd2, V2};
        vecs[18] = '{4'b0000, 4'b0000, 2'd2, V2};
        vecs[19] = '{4'b0000, 4'b0000, 2'd2, V2};
        vecs[20] = '{4'b0011, 4'b0001, 2'd0, V2};
        vecs[21] = '{4'b0011, 4'b0001, 2'd0, V0};
        vecs[22] = '{4'b1101, 4'b0001, 2'd0, V0};
        vecs[23] = '{4'b1101, 4'b0001, 2'd0, V0};
        vecs[24] = '{4'b1101, 4'b0100, 2'd2, V0};
        vecs[25] = '{4'b1101, 4'b0100, 2'd2, V2};

        val   = {V3, V2, V1, V0};
        req   = 4'b0000;
        req1  = 4'b0000;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check_all("reset", 4'b0000, 2'd3, 32'h0);

        for (int i = 0; i < 26; i++) begin
            req = vecs[i].req;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].owner, vecs[i].val);
        end

        // Asynchronous reset while holding, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 2'd3, 32'h0);
        req = 4'b0000;
        step();
        rst_n = 1'b1;
        step();
        check_all("post_rst", 4'b0000, 2'd3, 32'h0);

        // HOLD_CYCLES=1: grant rotates every cycle among active requesters.
        req1 = 4'b0101;
        step();
        check("h1 grant a", 32'(grant1), 32'h1);
        check("h1 owner a", 32'(owner1), 32'd0);
        check("h1 val a",   vout1,       32'h0);
        step();
        check("h1 grant b", 32'(grant1), 32'h4);
        check("h1 val b",   vout1,       V0);
        step();
        check("h1 grant c", 32'(grant1), 32'h1);
        check("h1 val c",   vout1,       V2);
        req1 = 4'b0000;
        step();
        check("h1 grant idle", 32'(grant1), 32'h0);
        check("h1 busy idle",  32'(busy1),  32'h0);
        check("h1 val idle",   vout1,       V0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
